puf_ro_compare: RTL and testbench

Response generator directly downstream of a pair of configurable ring-oscillator PUF cells. It drives the shared 6-bit challenge and enable into two oscillator instances and counts rising edges of each asynchronous oscillator output over a fixed gate window in the system clock domain. It then compares the two counts and emits one response bit per challenge with a valid pulse. It is the block the PUF top level uses to turn oscillator frequency mismatch into a digital response.

---
 rtl/puf_pkg.sv | 17 +
 rtl/puf_ro_compare_if.sv | 31 +++
 rtl/puf_edge_counter.sv | 47 ++++
 rtl/puf_ro_compare.sv | 128 ++++++++++++
 tb/tb_puf_ro_compare.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF response generator.
package puf_pkg;

  localparam int CHALLENGE_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } puf_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/puf_ro_compare_if.sv
// Bundle between the PUF top level and the response generator: request,
// oscillator drive/return and the registered response.
interface puf_ro_compare_if #(
  parameter int CNT_W = 16
);
  import puf_pkg::*;

  logic                   start;
  logic [CHALLENGE_W-1:0] challenge;
  logic [CHALLENGE_W-1:0] ro_challenge;
  logic                   ro_en;
  logic                   ro_a;
  logic                   ro_b;
  logic                   busy;
  logic                   resp_valid;
  logic                   resp_bit;
  logic                   tie;
  logic [CNT_W-1:0]       count_a;
  logic [CNT_W-1:0]       count_b;

  modport master (
    output start, challenge, ro_a, ro_b,
    input  ro_challenge, ro_en, busy, resp_valid, resp_bit, tie, count_a, count_b
  );

  modport slave (
    input  start, challenge, ro_a, ro_b,
    output ro_challenge, ro_en, busy, resp_valid, resp_bit, tie, count_a, count_b
  );

endinterface

// File: rtl/puf_edge_counter.sv
// Synchronises one free-running oscillator into clk, detects rising edges and
// accumulates them in a saturating counter while cnt_en is high.
module puf_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             ro_in,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  (* async_reg = "true" *) logic sync1_q;
  (* async_reg = "true" *) logic sync2_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             edge_det;

  assign edge_det = sync2_q & ~prev_q;
  assign count    = cnt_q;

  // Synchroniser, edge history and gated saturating edge counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (clr) begin
        cnt_q <= '0;
      end else if (cnt_en && edge_det && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

endmodule

// File: rtl/puf_ro_compare.sv
// Runs one settle + gate-window evaluation per accepted start, counts edges of
// both oscillators and reports which one ran faster.
module puf_ro_compare
  import puf_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst_n,
  puf_ro_compare_if.slave bus
);

  localparam int              PH_W        = $clog2(max_int(SETTLE_CYCLES, WINDOW_CYCLES) + 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] WINDOW_LAST = PH_W'(WINDOW_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_ONE      = PH_W'(1);

  puf_state_e             state_q;
  logic [PH_W-1:0]        phase_q;
  logic [CHALLENGE_W-1:0] chal_q;
  logic                   ro_en_q;
  logic                   busy_q;
  logic                   resp_valid_q;
  logic                   resp_bit_q;
  logic                   tie_q;

  logic                   start_acc;
  logic                   cnt_en;
  logic [CNT_W-1:0]       cnt_a;
  logic [CNT_W-1:0]       cnt_b;
  logic                   a_gt_b;
  logic                   a_eq_b;

  assign start_acc = (state_q == IDLE) && bus.start;
  assign cnt_en    = (state_q == COUNT);
  assign a_gt_b    = (cnt_a > cnt_b);
  assign a_eq_b    = (cnt_a == cnt_b);

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_acc),
    .cnt_en (cnt_en),
    .ro_in  (bus.ro_a),
    .count  (cnt_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_acc),
    .cnt_en (cnt_en),
    .ro_in  (bus.ro_b),
    .count  (cnt_b)
  );

  // Evaluation sequencer with its registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      chal_q       <= '0;
      ro_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_bit_q   <= 1'b0;
      tie_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            chal_q  <= bus.challenge;
            phase_q <= '0;
            ro_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end else begin
            state_q <= IDLE;
          end
        end
        SETTLE: begin
          if (phase_q == SETTLE_LAST) begin
            phase_q <= '0;
            state_q <= COUNT;
          end else begin
            phase_q <= phase_q + PH_ONE;
          end
        end
        COUNT: begin
          // The final window cycle's increment lands on the same edge as DONE.
          if (phase_q == WINDOW_LAST) begin
            ro_en_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            phase_q <= phase_q + PH_ONE;
          end
        end
        DONE: begin
          resp_bit_q <= a_gt_b;
          tie_q      <= a_eq_b;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          ro_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Counts are final only once DONE is entered, so the live comparison is
  // presented during the resp_valid cycle and the captured copy afterwards.
  assign bus.resp_bit     = (state_q == DONE) ? a_gt_b : resp_bit_q;
  assign bus.tie          = (state_q == DONE) ? a_eq_b : tie_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.busy         = busy_q;
  assign bus.ro_en        = ro_en_q;
  assign bus.ro_challenge = chal_q;
  assign bus.count_a      = cnt_a;
  assign bus.count_b      = cnt_b;

endmodule

// File: tb/tb_puf_ro_compare.sv
// Directed bench for puf_ro_compare with SETTLE=4, WINDOW=64 (resp 69 cycles
// after start); a second CNT_W=4 instance exercises counter saturation.
module tb_puf_ro_compare;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   half_a   = 0;
  int   half_b   = 0;
  int   half_f   = 0;
  int   tick     = 0;
  int   lat;
  logic seen;
  logic [31:0] res_a, res_b, res_bit, res_tie;
  int   pulses, p1, p2;

  puf_ro_compare_if #(.CNT_W(16)) bus1 ();
  puf_ro_compare_if #(.CNT_W(4))  bus2 ();

  puf_ro_compare #(.CNT_W(16), .SETTLE_CYCLES(4), .WINDOW_CYCLES(64)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  puf_ro_compare #(.CNT_W(4), .SETTLE_CYCLES(4), .WINDOW_CYCLES(64)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oscillator models: levels derived from a shared tick so equal periods stay phase-aligned.
  initial begin
    logic la, lb, lf;
    bus1.ro_a = 1'b0; bus1.ro_b = 1'b0; bus2.ro_a = 1'b0; bus2.ro_b = 1'b0;
    forever begin
      @(posedge clk); #2;
      tick = tick + 1;
      la = (half_a == 0) ? 1'b0 : (((tick / half_a) % 2) == 1);
      lb = (half_b == 0) ? 1'b0 : (((tick / half_b) % 2) == 1);
      lf = (half_f == 0) ? 1'b0 : (((tick / half_f) % 2) == 1);
      bus1.ro_a = la; bus1.ro_b = lb;
      bus2.ro_a = lf; bus2.ro_b = lb;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_eval(input logic [5:0] ch, input logic prev_bit);
    bus1.challenge = ch;
    bus1.start     = 1'b1;
    @(posedge clk); #1;
    bus1.start     = 1'b0;
    bus1.challenge = ~ch;
    chk("busy_after_start", 32'(bus1.busy), 32'd1);
    chk("ro_en_after_start", 32'(bus1.ro_en), 32'd1);
    chk("ro_chal_latch", 32'(bus1.ro_challenge), 32'(ch));
    chk("cnt_cleared", 32'(bus1.count_a), 32'd0);
    chk("resp_bit_held", 32'(bus1.resp_bit), 32'(prev_bit));
    lat = 1;
    while (!bus1.resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_latency", 32'(lat), 32'd69);
    chk("ro_en_done", 32'(bus1.ro_en), 32'd0);
    res_a   = 32'(bus1.count_a);
    res_b   = 32'(bus1.count_b);
    res_bit = 32'(bus1.resp_bit);
    res_tie = 32'(bus1.tie);
    @(posedge clk); #1;
    chk("resp_valid_single", 32'(bus1.resp_valid), 32'd0);
    chk("busy_after_done", 32'(bus1.busy), 32'd0);
    chk("ro_chal_idle_hold", 32'(bus1.ro_challenge), 32'(ch));
  endtask

  initial begin
    rst_n = 1'b0;
    bus1.start = 1'b0; bus1.challenge = 6'd0;
    bus2.start = 1'b0; bus2.challenge = 6'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ro_en", 32'(bus1.ro_en), 32'd0);
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_resp_valid", 32'(bus1.resp_valid), 32'd0);
    chk("rst_resp_bit", 32'(bus1.resp_bit), 32'd0);
    chk("rst_tie", 32'(bus1.tie), 32'd0);
    chk("rst_count_a", 32'(bus1.count_a), 32'd0);
    chk("rst_count_b", 32'(bus1.count_b), 32'd0);
    chk("rst_ro_chal", 32'(bus1.ro_challenge), 32'd0);

    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      seen = seen | bus1.ro_en | bus1.busy;
    end
    chk("idle_ro_en", 32'(seen), 32'd0);

    // A period 4, B period 6
    half_a = 2; half_b = 3;
    repeat (8) @(posedge clk); #1;
    run_eval(6'b101101, 1'b0);
    chk("t1_cnt_a_15_16", 32'(res_a == 32'd15 || res_a == 32'd16), 32'd1);
    chk("t1_cnt_b_10_11", 32'(res_b == 32'd10 || res_b == 32'd11), 32'd1);
    chk("t1_resp_bit", res_bit, 32'd1);
    chk("t1_tie", res_tie, 32'd0);

    // swapped periods
    half_a = 3; half_b = 2;
    repeat (8) @(posedge clk); #1;
    run_eval(6'b010010, 1'b1);
    chk("t2_cnt_a_10_11", 32'(res_a == 32'd10 || res_a == 32'd11), 32'd1);
    chk("t2_cnt_b_15_16", 32'(res_b == 32'd15 || res_b == 32'd16), 32'd1);
    chk("t2_resp_bit", res_bit, 32'd0);
    chk("t2_tie", res_tie, 32'd0);

    // equal, phase-aligned periods
    half_a = 2; half_b = 2;
    repeat (8) @(posedge clk); #1;
    run_eval(6'b000111, 1'b0);
    chk("t3_cnt_a", res_a, 32'd16);
    chk("t3_cnt_b", res_b, 32'd16);
    chk("t3_tie", res_tie, 32'd1);
    chk("t3_resp_bit", res_bit, 32'd0);
    repeat (5) @(posedge clk); #1;
    chk("t3_tie_hold", 32'(bus1.tie), 32'd1);
    chk("t3_count_hold", 32'(bus1.count_a), 32'd16);

    // saturation on the 4-bit instance: A period 2, B period 6
    half_f = 1; half_b = 3;
    repeat (8) @(posedge clk); #1;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    lat = 1;
    while (!bus2.resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("sat_latency", 32'(lat), 32'd69);
    chk("sat_cnt_a", 32'(bus2.count_a), 32'd15);
    chk("sat_cnt_b_10_11", 32'(bus2.count_b == 4'd10 || bus2.count_b == 4'd11), 32'd1);
    chk("sat_resp_bit", 32'(bus2.resp_bit), 32'd1);
    chk("sat_tie", 32'(bus2.tie), 32'd0);
    half_f = 0;

    // start held high across two evaluations
    half_a = 2; half_b = 3;
    repeat (8) @(posedge clk); #1;
    bus1.start = 1'b1;
    pulses = 0; p1 = 0; p2 = 0;
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk); #1;
      if (c == 140) bus1.start = 1'b0;
      if (bus1.resp_valid) begin
        pulses++;
        if (pulses == 1) p1 = c;
        else if (pulses == 2) p2 = c;
      end
      if (c == 70) chk("held_busy_idle", 32'(bus1.busy), 32'd0);
      if (c == 71) chk("held_busy_restart", 32'(bus1.busy), 32'd1);
    end
    chk("held_pulses", 32'(pulses), 32'd2);
    chk("held_first", 32'(p1), 32'd69);
    chk("held_second", 32'(p2), 32'd139);
    repeat (3) @(posedge clk); #1;

    // reset mid-COUNT
    bus1.challenge = 6'b111000;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("mid_ro_en", 32'(bus1.ro_en), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ro_en", 32'(bus1.ro_en), 32'd0);
    chk("abort_busy", 32'(bus1.busy), 32'd0);
    chk("abort_resp_bit", 32'(bus1.resp_bit), 32'd0);
    chk("abort_tie", 32'(bus1.tie), 32'd0);
    chk("abort_count_a", 32'(bus1.count_a), 32'd0);
    chk("abort_count_b", 32'(bus1.count_b), 32'd0);
    chk("abort_ro_chal", 32'(bus1.ro_challenge), 32'd0);
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      seen = seen | bus1.resp_valid;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    run_eval(6'b110011, 1'b0);
    chk("post_rst_resp_bit", res_bit, 32'd1);
    chk("post_rst_tie", res_tie, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
